// File: rtl/piso_serializer_if.sv
// Load handshake and serial output bundle for piso_serializer.
// The master drives words in; the slave (the serializer) drives the serial side.
interface piso_serializer_if #(
    parameter int WIDTH = 4
) ();
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             sout;
    logic             sout_valid;
    logic             frame_start;
    logic             frame_done;
    logic             busy;

    modport master (
        output load_data,
        output load_valid,
        input  load_ready,
        input  sout,
        input  sout_valid,
        input  frame_start,
        input  frame_done,
        input  busy
    );

    modport slave (
        input  load_data,
        input  load_valid,
        output load_ready,
        output sout,
        output sout_valid,
        output frame_start,
        output frame_done,
        output busy
    );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter: one WIDTH-bit word per frame, one bit per clk,
// back-to-back frames with no idle gap. Outputs decode from state registers only.
module piso_serializer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    piso_serializer_if.slave    bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;

    logic w_last;
    logic w_ready;
    logic w_sout;
    logic w_valid;
    logic w_start;
    logic w_done;

    // Move the next bit to be sent into the output end, zero-filling behind it.
    function automatic logic [WIDTH-1:0] shift_toward_out(input logic [WIDTH-1:0] v);
        if (MSB_FIRST) begin
            return {v[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, v[WIDTH-1:1]};
        end
    endfunction

    // Output decode from the registered state only; load_valid/load_data never reach an output.
    always_comb begin
        w_last  = 1'b0;
        w_ready = 1'b0;
        w_sout  = 1'b0;
        w_valid = 1'b0;
        w_start = 1'b0;
        w_done  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
            end
            ST_SHIFT: begin
                w_last  = (r_cnt == LAST_CNT);
                w_ready = w_last;
                w_sout  = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
                w_valid = 1'b1;
                w_start = (r_cnt == {CW{1'b0}});
                w_done  = w_last;
            end
            default: begin
                w_ready = 1'b0;
            end
        endcase
    end

    assign bus.load_ready  = w_ready;
    assign bus.sout        = w_sout;
    assign bus.sout_valid  = w_valid;
    assign bus.busy        = w_valid;
    assign bus.frame_start = w_start;
    assign bus.frame_done  = w_done;

    // Frame FSM; a word offered on the last bit reloads in place so frames abut.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_shreg <= {WIDTH{1'b0}};
            r_cnt   <= {CW{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.load_valid) begin
                        r_state <= ST_SHIFT;
                        r_shreg <= bus.load_data;
                        r_cnt   <= {CW{1'b0}};
                    end
                end
                ST_SHIFT: begin
                    if (r_cnt != LAST_CNT) begin
                        r_shreg <= shift_toward_out(r_shreg);
                        r_cnt   <= r_cnt + CW'(1);
                    end else if (bus.load_valid) begin
                        r_state <= ST_SHIFT;
                        r_shreg <= bus.load_data;
                        r_cnt   <= {CW{1'b0}};
                    end else begin
                        r_state <= ST_IDLE;
                        r_shreg <= {WIDTH{1'b0}};
                        r_cnt   <= {CW{1'b0}};
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_shreg <= {WIDTH{1'b0}};
                    r_cnt   <= {CW{1'b0}};
                end
            endcase
        end
    end
endmodule
